// File: rtl/hack_boot_ctrl.sv
// Boot/run controller for the Hack CPU: streams a length-prefixed big-endian
// program into instruction ROM, then releases the CPU with run/halt/step gating.
module hack_boot_ctrl #(
  parameter int unsigned ROM_DEPTH = 32768,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  input  logic              halt,
  input  logic              step,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, W_HI, W_LO, RUN, ERR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q;
  logic [7:0]        hi_q;
  logic [15:0]       wdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       words_q;
  logic              last_q;
  logic              xfer;
  logic              start_ok;
  logic [15:0]       hdr_len;
  logic              word_is_last;

  assign xfer         = byte_valid & byte_ready;
  assign start_ok     = start & ((state_q == IDLE) | (state_q == RUN) | (state_q == ERR));
  assign hdr_len      = {len_q[15:8], byte_data};
  assign word_is_last = ((words_q + 16'd1) == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The final word parks in W_LO (byte_ready low) for its write cycle, so RUN
  // begins only once the last rom_we has been issued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN, ERR: if (start) state_d = LEN_HI;
      LEN_HI:         if (xfer) state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (32'(hdr_len) > ROM_DEPTH) state_d = ERR;
          else if (hdr_len == 16'd0)    state_d = RUN;
          else                          state_d = W_HI;
        end
      end
      W_HI:           if (xfer) state_d = W_LO;
      W_LO: begin
        if (last_q)    state_d = RUN;
        else if (xfer) state_d = word_is_last ? W_LO : W_HI;
      end
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      words_q <= '0;
      last_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) begin
        words_q <= words_q + 16'd1;
        if (!last_q) addr_q <= addr_q + 1'b1;
      end
      if ((state_q == W_LO) && last_q) last_q <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          LEN_HI: len_q[15:8] <= byte_data;
          LEN_LO: len_q[7:0]  <= byte_data;
          W_HI:   hi_q        <= byte_data;
          W_LO: begin
            wdata_q <= {hi_q, byte_data};
            we_q    <= 1'b1;
            last_q  <= word_is_last;
          end
          default: ;
        endcase
      end
      if (start_ok) begin
        addr_q  <= '0;
        words_q <= '0;
        last_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    cpu_clk_en = 1'b0;
    unique case (state_q)
      LEN_HI, LEN_LO, W_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      W_LO: begin
        byte_ready = ~last_q;
        busy       = 1'b1;
      end
      RUN: begin
        cpu_reset  = 1'b0;
        cpu_clk_en = ~start & (~halt | step);
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  assign rom_we       = we_q;
  assign rom_addr     = addr_q;
  assign rom_wdata    = wdata_q;
  assign words_loaded = words_q;

endmodule
